// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to two of four functional-unit results per
// cycle in round-robin order and broadcasts them on a registered two-slot CDB.
//
// Handshake: req[i] with req_tag/req_data slice i is an offer; grant[i] is
// combinational acceptance in the same cycle. A transfer happens on a rising
// edge where req[i] and grant[i] are both 1. A requester whose grant bit is 0
// keeps req, tag and data unchanged, because nothing is stored on its behalf.
module cdb_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_tag,
    input  logic [32*NREQ-1:0]  req_data,
    input  logic                flush,
    output logic [NREQ-1:0]     grant,
    output logic [147:0]        CDB,
    output logic [1:0]          rr_ptr
);

    // Broadcast slot registers (slot 0 carries grant A, slot 1 grant B).
    logic [2:0]  s0_tag_q,  s0_tag_d;
    logic        s0_vld_q,  s0_vld_d;
    logic [31:0] s0_data_q, s0_data_d;
    logic [2:0]  s1_tag_q,  s1_tag_d;
    logic        s1_vld_q,  s1_vld_d;
    logic [31:0] s1_data_q, s1_data_d;
    logic [1:0]  rr_ptr_q,  rr_ptr_d;

    // Arbitration intermediates.
    logic [3:0]  req_eff;
    logic [3:0]  req_rot;
    logic [3:0]  req_rest;
    logic        a_vld;
    logic        b_vld;
    logic [1:0]  a_off;
    logic [1:0]  b_off;
    logic [1:0]  a_idx;
    logic [1:0]  b_idx;
    logic [3:0]  grant_a;
    logic [3:0]  grant_b;
    logic [2:0]  a_tag;
    logic [31:0] a_data;
    logic [2:0]  b_tag;
    logic [31:0] b_data;

    // Lowest set bit of a 4-bit vector: {found, index}.
    function automatic logic [2:0] first_set(input logic [3:0] v);
        logic [2:0] r;
        if (v[0])      r = 3'b100;
        else if (v[1]) r = 3'b101;
        else if (v[2]) r = 3'b110;
        else if (v[3]) r = 3'b111;
        else           r = 3'b000;
        return r;
    endfunction

    // Rotate the requests so the pointer position is bit 0, then take the
    // first two set bits; rotating back is just adding the pointer mod 4.
    always_comb begin
        req_eff = (Reset || flush) ? 4'b0000 : req;
        case (rr_ptr_q)
            2'd0:    req_rot = req_eff;
            2'd1:    req_rot = {req_eff[0],   req_eff[3:1]};
            2'd2:    req_rot = {req_eff[1:0], req_eff[3:2]};
            2'd3:    req_rot = {req_eff[2:0], req_eff[3]};
            default: req_rot = req_eff;
        endcase
        // Clearing the lowest set bit removes A; every bit below A is already
        // zero, so the next set bit is the first one after A circularly.
        req_rest       = req_rot & (req_rot - 4'd1);
        {a_vld, a_off} = first_set(req_rot);
        {b_vld, b_off} = first_set(req_rest);
        a_idx          = rr_ptr_q + a_off;
        b_idx          = rr_ptr_q + b_off;
        grant_a        = a_vld ? (4'b0001 << a_idx) : 4'b0000;
        grant_b        = b_vld ? (4'b0001 << b_idx) : 4'b0000;
    end

    assign grant = grant_a | grant_b;

    // Select the tag and data of the two winners.
    always_comb begin
        a_tag  = req_tag[a_idx*3 +: 3];
        a_data = req_data[a_idx*32 +: 32];
        b_tag  = req_tag[b_idx*3 +: 3];
        b_data = req_data[b_idx*32 +: 32];
    end

    // Next CDB contents and pointer: load winners, otherwise drop valid and
    // keep the payload fields; the pointer moves just past the last winner.
    always_comb begin
        s0_tag_d  = s0_tag_q;
        s0_data_d = s0_data_q;
        s0_vld_d  = 1'b0;
        s1_tag_d  = s1_tag_q;
        s1_data_d = s1_data_q;
        s1_vld_d  = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        if (a_vld) begin
            s0_tag_d  = a_tag;
            s0_data_d = a_data;
            s0_vld_d  = 1'b1;
            rr_ptr_d  = a_idx + 2'd1;
        end
        if (b_vld) begin
            s1_tag_d  = b_tag;
            s1_data_d = b_data;
            s1_vld_d  = 1'b1;
            rr_ptr_d  = b_idx + 2'd1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s0_tag_q  <= 3'd0;
            s0_vld_q  <= 1'b0;
            s0_data_q <= 32'd0;
            s1_tag_q  <= 3'd0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= 32'd0;
            rr_ptr_q  <= 2'd0;
        end else begin
            s0_tag_q  <= s0_tag_d;
            s0_vld_q  <= s0_vld_d;
            s0_data_q <= s0_data_d;
            s1_tag_q  <= s1_tag_d;
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign CDB    = {76'd0,
                     s1_data_q, s1_vld_q, s1_tag_q,
                     s0_data_q, s0_vld_q, s0_tag_q};
    assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks for the CDB arbiter.
module tb_cdb_arbiter;

    logic         CLK;
    logic         Reset;
    logic [3:0]   req;
    logic [11:0]  req_tag;
    logic [127:0] req_data;
    logic         flush;
    logic [3:0]   grant;
    logic [147:0] CDB;
    logic [1:0]   rr_ptr;

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter #(.NREQ(4)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .req      (req),
        .req_tag  (req_tag),
        .req_data (req_data),
        .flush    (flush),
        .grant    (grant),
        .CDB      (CDB),
        .rr_ptr   (rr_ptr)
    );

    // Clock: rising edges at 5, 15, 25 ...; the bench works on falling edges.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [147:0] obs, input logic [147:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input int s, input logic v,
                            input logic [2:0] t, input logic [31:0] d);
        logic [35:0] obs;
        obs = (s == 0) ? CDB[35:0] : CDB[71:36];
        chk(tag, {112'd0, obs}, {112'd0, d, v, t});
    endtask

    task automatic set_r(input int i, input logic [2:0] t, input logic [31:0] d);
        req_tag[i*3 +: 3]   = t;
        req_data[i*32 +: 32] = d;
    endtask

    // Reference arbitration: walk circularly from the pointer, the first two
    // requesters found are A and B.
    function automatic logic [3:0] model_grant(input logic [3:0] r, input logic [1:0] p,
                                               output int a, output int b);
        logic [3:0] g;
        int idx;
        g = 4'b0000;
        a = -1;
        b = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (int'(p) + k) % 4;
            if (r[idx]) begin
                if (a < 0) begin
                    a = idx;
                    g[idx] = 1'b1;
                end else if (b < 0) begin
                    b = idx;
                    g[idx] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    logic [71:0] m_cdb;
    logic [1:0]  m_rr;
    logic [3:0]  eg;
    logic [3:0]  eg_prev;
    int          ma;
    int          mb;
    int          wait_c [4];

    initial begin
        Reset    = 1'b0;
        flush    = 1'b0;
        req      = 4'b0000;
        req_tag  = '0;
        req_data = '0;

        // Reset holds everything at zero, even with all requests up.
        #1 Reset = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_r(i, 3'(i), 32'hA0 + 32'(i));
        #1;
        chk("reset_cdb",   CDB, 148'd0);
        chk("reset_rr",    {146'd0, rr_ptr}, 148'd0);
        chk("reset_grant", {144'd0, grant}, 148'd0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        #1 chk("all4_grant1", {144'd0, grant}, 148'h3);

        @(negedge CLK);
        chk_slot("all4_s0", 0, 1'b1, 3'd0, 32'hA0);
        chk_slot("all4_s1", 1, 1'b1, 3'd1, 32'hA1);
        chk("all4_rr", {146'd0, rr_ptr}, 148'd2);
        chk("all4_reserved", {72'd0, CDB[147:72]}, 148'd0);
        #1 chk("all4_grant2", {144'd0, grant}, 148'hC);

        @(negedge CLK);
        chk_slot("all4b_s0", 0, 1'b1, 3'd2, 32'hA2);
        chk_slot("all4b_s1", 1, 1'b1, 3'd3, 32'hA3);
        chk("all4b_rr", {146'd0, rr_ptr}, 148'd0);
        req = 4'b0100;
        set_r(2, 3'd5, 32'h1234);
        #1 chk("single_grant", {144'd0, grant}, 148'h4);

        @(negedge CLK);
        chk_slot("single_s0", 0, 1'b1, 3'd5, 32'h1234);
        chk_slot("single_s1", 1, 1'b0, 3'd3, 32'hA3);
        chk("single_rr", {146'd0, rr_ptr}, 148'd3);
        req = 4'b0000;
        #1 chk("idle_grant", {144'd0, grant}, 148'h0);

        @(negedge CLK);
        chk_slot("idle_s0", 0, 1'b0, 3'd5, 32'h1234);
        chk_slot("idle_s1", 1, 1'b0, 3'd3, 32'hA3);
        chk("idle_rr", {146'd0, rr_ptr}, 148'd3);
        req = 4'b1001;
        set_r(3, 3'd6, 32'h33);
        set_r(0, 3'd7, 32'h30);
        #1 chk("wrap_grant", {144'd0, grant}, 148'h9);

        @(negedge CLK);
        chk_slot("wrap_s0", 0, 1'b1, 3'd6, 32'h33);
        chk_slot("wrap_s1", 1, 1'b1, 3'd7, 32'h30);
        chk("wrap_rr", {146'd0, rr_ptr}, 148'd1);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_r(i, 3'(i), 32'hB0 + 32'(i));
        flush = 1'b1;
        #1 chk("flush_grant", {144'd0, grant}, 148'h0);

        @(negedge CLK);
        chk_slot("flush_s0", 0, 1'b0, 3'd6, 32'h33);
        chk_slot("flush_s1", 1, 1'b0, 3'd7, 32'h30);
        chk("flush_rr", {146'd0, rr_ptr}, 148'd1);
        flush = 1'b0;
        #1 chk("resume_grant", {144'd0, grant}, 148'h6);

        @(negedge CLK);
        chk_slot("resume_s0", 0, 1'b1, 3'd1, 32'hB1);
        chk_slot("resume_s1", 1, 1'b1, 3'd2, 32'hB2);
        chk("resume_rr", {146'd0, rr_ptr}, 148'd3);
        req = 4'b1010;
        set_r(3, 3'd4, 32'hC3);
        set_r(1, 3'd4, 32'hC1);
        #1 chk("dup_grant", {144'd0, grant}, 148'hA);

        @(negedge CLK);
        chk_slot("dup_s0", 0, 1'b1, 3'd4, 32'hC3);
        chk_slot("dup_s1", 1, 1'b1, 3'd4, 32'hC1);
        chk("dup_rr", {146'd0, rr_ptr}, 148'd2);
        req = 4'b1000;
        set_r(3, 3'd2, 32'hD3);
        #1 chk("one3_grant", {144'd0, grant}, 148'h8);

        @(negedge CLK);
        chk_slot("one3_s0", 0, 1'b1, 3'd2, 32'hD3);
        chk_slot("one3_s1", 1, 1'b0, 3'd4, 32'hC1);
        chk("one3_rr_wrap", {146'd0, rr_ptr}, 148'd0);
        // Reset inside the grant cycle: the result must never reach the CDB.
        req = 4'b0011;
        set_r(0, 3'd1, 32'hE0);
        set_r(1, 3'd2, 32'hE1);
        #1 chk("rst1_grant", {144'd0, grant}, 148'h3);
        #2 Reset = 1'b1;
        #1;
        chk("rst1_cdb_now",   CDB, 148'd0);
        chk("rst1_rr_now",    {146'd0, rr_ptr}, 148'd0);
        chk("rst1_grant_now", {144'd0, grant}, 148'h0);
        @(negedge CLK);
        chk("rst1_cdb_edge", CDB, 148'd0);
        req   = 4'b0000;
        Reset = 1'b0;
        @(negedge CLK);
        chk("rst1_cdb_after", CDB, 148'd0);
        chk("rst1_rr_after",  {146'd0, rr_ptr}, 148'd0);
        // Reset in the broadcast cycle: cleared without waiting for an edge.
        req = 4'b0011;
        #1 chk("rst2_grant", {144'd0, grant}, 148'h3);
        @(negedge CLK);
        chk_slot("rst2_s0", 0, 1'b1, 3'd1, 32'hE0);
        chk_slot("rst2_s1", 1, 1'b1, 3'd2, 32'hE1);
        chk("rst2_rr", {146'd0, rr_ptr}, 148'd2);
        req = 4'b0000;
        #1 Reset = 1'b1;
        #1;
        chk("rst2_cdb_now", CDB, 148'd0);
        chk("rst2_rr_now",  {146'd0, rr_ptr}, 148'd0);
        @(negedge CLK);
        Reset = 1'b0;
        req   = 4'b0100;
        set_r(2, 3'd3, 32'hF2);
        #1 chk("post_rst_grant", {144'd0, grant}, 148'h4);
        @(negedge CLK);
        chk_slot("post_rst_s0", 0, 1'b1, 3'd3, 32'hF2);
        chk("post_rst_rr", {146'd0, rr_ptr}, 148'd3);

        // Randomized traffic with a reference model, starting from a clean reset.
        req = 4'b0000;
        #1 Reset = 1'b1;
        #1 Reset = 1'b0;
        m_cdb   = '0;
        m_rr    = 2'd0;
        eg_prev = 4'b0000;
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge CLK);
            chk("rnd_cdb", CDB, {76'd0, m_cdb});
            chk("rnd_rr", {146'd0, rr_ptr}, {146'd0, m_rr});
            for (int i = 0; i < 4; i++) begin
                if (!(req[i] && !eg_prev[i])) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    set_r(i, 3'($urandom_range(0, 7)), $urandom());
                end
            end
            #1;
            eg = model_grant(req, m_rr, ma, mb);
            chk("rnd_grant", {144'd0, grant}, {144'd0, eg});
            chk("rnd_legal", {147'd0, ($countones(grant) <= 2) && ((grant & ~req) == 4'b0000)},
                148'd1);
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !eg[i]) wait_c[i]++;
                else wait_c[i] = 0;
                chk("rnd_starve", {147'd0, wait_c[i] <= 1}, 148'd1);
            end
            if (ma >= 0) m_cdb[35:0] = {req_data[ma*32 +: 32], 1'b1, req_tag[ma*3 +: 3]};
            else         m_cdb[3] = 1'b0;
            if (mb >= 0) m_cdb[71:36] = {req_data[mb*32 +: 32], 1'b1, req_tag[mb*3 +: 3]};
            else         m_cdb[39] = 1'b0;
            if (mb >= 0)      m_rr = 2'(mb + 1);
            else if (ma >= 0) m_rr = 2'(ma + 1);
            eg_prev = eg;
        end
        @(negedge CLK);
        chk("rnd_cdb_last", CDB, {76'd0, m_cdb});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of functional-unit requesters; only the value 4 is supported.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  bit i set: requester i presents a result this cycle.
REQ-005 req_tag  input  12  ROB index of requester i, in bits [3i+2:3i].
REQ-006 req_data  input  128  result value of requester i, in bits [32i+31:32i].
REQ-007 flush  input  1  squash: no grants this cycle; clear the CDB on the next edge.
REQ-008 grant  output  4  combinational; bit i set: requester i's result is accepted this cycle.
REQ-009 CDB  output  148  registered broadcast bus.
- Slot 0: [2:0] tag, [3] valid, [35:4] data.
- Slot 1: [38:36] tag, [39] valid, [71:40] data.
- Bits [147:72] are reserved and driven 0.
REQ-010 rr_ptr  output  2  current round-robin priority pointer (debug).

Function
REQ-011 The block SHALL grant at most two requesters per cycle and never grant a requester whose req bit is 0.
REQ-012 Grant A SHALL go to the first requester with req set, scanning circularly from rr_ptr: rr_ptr, rr_ptr+1, ... mod 4.
REQ-013 Grant B SHALL go to the next requester with req set, scanning circularly from A+1 and excluding A.
REQ-014 If fewer than two requesters are active, the missing grant(s) SHALL be absent.
REQ-015 grant SHALL be a pure function of req, rr_ptr and flush, valid in the same cycle.
- A requester seeing its grant bit clear SHALL hold req, tag and data unchanged.
- The arbiter itself does not register unaccepted requests.
REQ-016 On a rising edge with at least one grant, A's tag and data SHALL be written to slot 0 with valid=1.
REQ-017 On the same edge, B's tag and data (if B exists) SHALL be written to slot 1 with valid=1; otherwise slot 1 valid=0.
REQ-018 On an edge with no grant, both slot valid bits SHALL be 0; tag and data fields SHALL hold their previous values.
REQ-019 Broadcast latency SHALL be exactly one cycle from the grant cycle, and each CDB valid SHALL be asserted for exactly one cycle per grant.
REQ-020 rr_ptr update per edge:
- Two grants: (B+1) mod 4.
- One grant: (A+1) mod 4.
- No grant: unchanged.
REQ-021 Wrap-around: a granted index of 3 SHALL give a next pointer of 0.
REQ-022 Starvation bound: a requester holding req continuously SHALL be granted within 2 cycles.
REQ-023 flush=1 SHALL force grant=0 in that cycle; on the next edge both CDB valid bits SHALL be 0 and rr_ptr SHALL be unchanged.
REQ-024 flush SHALL override any simultaneous req combination.
REQ-025 Tags SHALL pass through unmodified; the arbiter SHALL NOT compare, merge or deduplicate equal tags from different requesters.

Reset
REQ-026 While Reset=1, the block SHALL hold:
- CDB = 0 (all 148 bits);
- rr_ptr = 0;
- grant = 0.
REQ-027 Reset assertion SHALL take effect immediately, independent of CLK.
REQ-028 A Reset asserted in the cycle after a grant SHALL drop that pending broadcast; the result is lost and the requester is not re-granted.
REQ-029 On the first edge after Reset deasserts, the block SHALL arbitrate normally from rr_ptr=0.

Verification
REQ-030 After reset, req=4'b1111, tags 0..3, data 0xA0..0xA3:
- grant=4'b0011.
- Next cycle: CDB slot0={tag 0, 0xA0, v=1}, slot1={tag 1, 0xA1, v=1}, rr_ptr=2.
- Next grant=4'b1100.
REQ-031 rr_ptr=3, req=4'b1001:
- grant=4'b1001.
- Next cycle: slot0 = requester 3, slot1 = requester 0, rr_ptr=1.
REQ-032 Single req=4'b0100, tag 5, data 0x1234:
- grant=4'b0100.
- Next cycle: slot0={5, 0x1234, v=1}, slot1 v=0, rr_ptr=3.
- Following cycle, with req=0: both valid bits 0.
REQ-033 req=4'b1111 held and flush=1 for one cycle:
- grant=0.
- Next cycle: CDB[3]=0, CDB[39]=0, rr_ptr unchanged.
- Arbitration resumes the cycle after.
REQ-034 Reset pulsed mid-cycle (between edges) after a grant:
- CDB=0 and rr_ptr=0 immediately, without waiting for a clock edge.
- The dropped result never appears on the CDB.
REQ-035 Random req for 10k cycles; the checker SHALL confirm:
- at most 2 grants per cycle, and only to requesting units;
- no continuously requesting unit waits more than 2 cycles;
- every CDB valid slot matches a grant from the prior cycle.
